// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: aligns loads/stores onto a word-wide handshaked bus,
// stalls the pipeline while the bus access is outstanding and returns extended load data.
module load_store_unit #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_read_i,
   input  logic        req_write_i,
   input  logic [2:0]  req_func3_i,
   input  logic [31:0] req_address_i,
   input  logic [31:0] req_store_data_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_data_o,
   output logic        resp_error_o,
   output logic        stall_o,
   output logic [31:0] bus_address_o,
   output logic [31:0] bus_write_data_o,
   output logic [3:0]  bus_byte_enable_o,
   output logic        bus_read_o,
   output logic        bus_write_o,
   input  logic [31:0] bus_read_data_i,
   input  logic        bus_ack_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

   state_t      state_q, state_d;
   logic [2:0]  func3_q, func3_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [31:0] bus_address_q, bus_address_d;
   logic [31:0] bus_write_data_q, bus_write_data_d;
   logic [3:0]  bus_byte_enable_q, bus_byte_enable_d;
   logic        bus_read_q, bus_read_d;
   logic        bus_write_q, bus_write_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        resp_error_q, resp_error_d;

   logic        is_byte, is_half, is_word;
   logic        legal_func3, misaligned, req_ok;
   logic [3:0]  req_be;
   logic [31:0] req_wd;
   logic [31:0] lane;
   logic [31:0] load_ext;

   assign is_byte = (req_func3_i[1:0] == 2'b00);
   assign is_half = (req_func3_i[1:0] == 2'b01);
   assign is_word = (req_func3_i[1:0] == 2'b10);

   // Unsigned variants (bit 2) exist only for byte and half loads.
   assign legal_func3 = req_read_i ? ((req_func3_i == 3'b010) || (!is_word && !req_func3_i[1]))
                                   : (!req_func3_i[2] && (req_func3_i[1:0] != 2'b11));
   assign misaligned  = (is_half && req_address_i[0]) || (is_word && (req_address_i[1:0] != 2'b00));
   assign req_ok      = !(req_read_i && req_write_i) && legal_func3 && !misaligned;

   always_comb begin
      req_be = 4'b1111;
      req_wd = req_store_data_i;
      if (is_byte) begin
         req_be = 4'b0001 << req_address_i[1:0];
         req_wd = {4{req_store_data_i[7:0]}};
      end else if (is_half) begin
         req_be = 4'b0011 << req_address_i[1:0];
         req_wd = {2{req_store_data_i[15:0]}};
      end
   end

   assign lane = bus_read_data_i >> {addr_lo_q, 3'b000};

   always_comb begin
      case (func3_q)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_ext = {24'd0, lane[7:0]};
         3'b101:  load_ext = {16'd0, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   always_comb begin
      state_d           = state_q;
      func3_d           = func3_q;
      addr_lo_d         = addr_lo_q;
      bus_address_d     = bus_address_q;
      bus_write_data_d  = bus_write_data_q;
      bus_byte_enable_d = bus_byte_enable_q;
      bus_read_d        = bus_read_q;
      bus_write_d       = bus_write_q;
      cnt_d             = cnt_q;
      resp_data_d       = resp_data_q;
      resp_error_d      = resp_error_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i && (req_read_i || req_write_i)) begin
               if (req_ok) begin
                  state_d           = ACCESS;
                  func3_d           = req_func3_i;
                  addr_lo_d         = req_address_i[1:0];
                  bus_address_d     = {req_address_i[31:2], 2'b00};
                  bus_write_data_d  = req_wd;
                  bus_byte_enable_d = req_be;
                  bus_read_d        = req_read_i;
                  bus_write_d       = req_write_i;
                  cnt_d             = '0;
               end else begin
                  state_d      = RESPOND;
                  resp_data_d  = 32'd0;
                  resp_error_d = 1'b1;
               end
            end
         end
         ACCESS: begin
            // An ack arriving on the final allowed cycle still completes cleanly.
            if (bus_ack_i) begin
               state_d      = RESPOND;
               bus_read_d   = 1'b0;
               bus_write_d  = 1'b0;
               resp_data_d  = bus_read_q ? load_ext : 32'd0;
               resp_error_d = 1'b0;
            end else if ((MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               state_d      = RESPOND;
               bus_read_d   = 1'b0;
               bus_write_d  = 1'b0;
               resp_data_d  = 32'd0;
               resp_error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q           <= IDLE;
         func3_q           <= 3'd0;
         addr_lo_q         <= 2'd0;
         bus_address_q     <= 32'd0;
         bus_write_data_q  <= 32'd0;
         bus_byte_enable_q <= 4'd0;
         bus_read_q        <= 1'b0;
         bus_write_q       <= 1'b0;
         cnt_q             <= '0;
         resp_data_q       <= 32'd0;
         resp_error_q      <= 1'b0;
      end else begin
         state_q           <= state_d;
         func3_q           <= func3_d;
         addr_lo_q         <= addr_lo_d;
         bus_address_q     <= bus_address_d;
         bus_write_data_q  <= bus_write_data_d;
         bus_byte_enable_q <= bus_byte_enable_d;
         bus_read_q        <= bus_read_d;
         bus_write_q       <= bus_write_d;
         cnt_q             <= cnt_d;
         resp_data_q       <= resp_data_d;
         resp_error_q      <= resp_error_d;
      end
   end

   assign req_ready_o       = (state_q == IDLE);
   assign stall_o           = (state_q == ACCESS);
   assign resp_valid_o      = (state_q == RESPOND);
   assign resp_data_o       = resp_data_q;
   assign resp_error_o      = resp_error_q;
   assign bus_address_o     = bus_address_q;
   assign bus_write_data_o  = bus_write_data_q;
   assign bus_byte_enable_o = bus_byte_enable_q;
   assign bus_read_o        = bus_read_q;
   assign bus_write_o       = bus_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: responses are checked against a queue of
// expected results filled when each request is issued.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
   logic [2:0]  req_func3 = 3'd0;
   logic [31:0] req_address = 32'd0, req_store_data = 32'd0;
   logic        req_ready, resp_valid, resp_error, stall, bus_read, bus_write;
   logic [31:0] resp_data, bus_address, bus_write_data;
   logic [3:0]  bus_byte_enable;
   logic [31:0] bus_read_data = 32'd0;
   logic        bus_ack = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } resp_t;
   resp_t exp_q[$];

   always #5 clk = ~clk;

   load_store_unit #(.MEM_TIMEOUT(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_read_i(req_read), .req_write_i(req_write),
      .req_func3_i(req_func3), .req_address_i(req_address),
      .req_store_data_i(req_store_data),
      .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_error_o(resp_error),
      .stall_o(stall),
      .bus_address_o(bus_address), .bus_write_data_o(bus_write_data),
      .bus_byte_enable_o(bus_byte_enable),
      .bus_read_o(bus_read), .bus_write_o(bus_write),
      .bus_read_data_i(bus_read_data), .bus_ack_i(bus_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every response strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (resp_valid) begin
         resp_t e;
         chk("resp_pending", 32'(exp_q.size()), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_data", resp_data, e.data);
            chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
            $display("resp data=%h err=%0b", resp_data, resp_error);
         end
      end
   end

   task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req_valid = 1'b1; req_read = rd; req_write = wr;
      req_func3 = f3; req_address = a; req_store_data = d;
      @(posedge clk); #1;
      req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
   endtask

   task automatic access(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rdata, input int waits,
                         input logic [31:0] exp_ba, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_data, input bit poke);
      exp_q.push_back('{exp_data, 1'b0});
      do_req(rd, !rd, f3, a, d);
      for (int i = 0; i <= waits; i++) begin
         chk("stall", {31'd0, stall}, 32'd1);
         chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
         chk("bus_read", {31'd0, bus_read}, {31'd0, rd});
         chk("bus_write", {31'd0, bus_write}, {31'd0, !rd});
         chk("bus_address", bus_address, exp_ba);
         chk("bus_byte_enable", {28'd0, bus_byte_enable}, {28'd0, exp_be});
         if (!rd) chk("bus_write_data", bus_write_data, exp_wd);
         if (poke && i == 1) begin
            req_valid = 1'b1; req_write = 1'b1; req_func3 = 3'b010; req_address = 32'h400;
         end
         if (i == waits) begin
            bus_ack = 1'b1; bus_read_data = rdata;
         end
         @(posedge clk); #1;
         bus_ack = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      end
      chk("resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("strobes_off", {30'd0, bus_read, bus_write}, 32'd0);
      chk("stall_off", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic err_req(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
      exp_q.push_back('{32'd0, 1'b1});
      do_req(rd, wr, f3, a, 32'hFFFF_FFFF);
      chk("err_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("err_no_stall", {31'd0, stall}, 32'd0);
      chk("err_no_strobe", {30'd0, bus_read, bus_write}, 32'd0);
      @(posedge clk); #1;
      chk("err_req_ready", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      #2;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
      chk("rst_bus_address", bus_address, 32'd0);
      chk("rst_byte_enable", {28'd0, bus_byte_enable}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      @(negedge clk); rst = 1'b0;

      // Byte loads on the top lane, signed then unsigned.
      access(1'b1, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0, 32'h100, 4'b1000, 32'd0, 32'hFFFF_FF80, 1'b0);
      access(1'b1, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0, 32'h100, 4'b1000, 32'd0, 32'h0000_0080, 1'b0);
      // Stores: half on upper lane, byte on lane 1.
      access(1'b0, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'd0, 0, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'd0, 1'b0);
      access(1'b0, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'd0, 1, 32'h200, 4'b0010, 32'hABAB_ABAB, 32'd0, 1'b0);
      // Misaligned, illegal func3, and both strobes.
      err_req(1'b1, 1'b0, 3'b010, 32'h0000_0101);
      err_req(1'b1, 1'b0, 3'b011, 32'h0000_0100);
      err_req(1'b0, 1'b1, 3'b100, 32'h0000_0100);
      err_req(1'b1, 1'b1, 3'b010, 32'h0000_0100);
      err_req(1'b0, 1'b1, 3'b001, 32'h0000_0203);
      // Delayed ack with an ignored request pulse in flight; LHU on lane 0.
      access(1'b1, 3'b001, 32'h0000_000A, 32'd0, 32'h9ABC_5678, 3, 32'h008, 4'b1100, 32'd0, 32'hFFFF_9ABC, 1'b1);
      access(1'b1, 3'b101, 32'h0000_0008, 32'd0, 32'h9ABC_F678, 0, 32'h008, 4'b0011, 32'd0, 32'h0000_F678, 1'b0);

      // Store timeout: strobe held for exactly the limit, then an error response.
      exp_q.push_back('{32'd0, 1'b1});
      do_req(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'h1122_3344);
      n = 0;
      while (bus_write && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      chk("timeout_cycles", 32'(n), 32'd16);
      chk("timeout_resp_valid", {31'd0, resp_valid}, 32'd1);
      @(posedge clk); #1;
      // Ack on the last allowed cycle wins.
      access(1'b0, 3'b010, 32'h0000_0500, 32'h1122_3344, 32'd0, 15, 32'h500, 4'b1111, 32'h1122_3344, 32'd0, 1'b0);

      // Asynchronous reset mid-access abandons it without a response.
      do_req(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0);
      chk("pre_rst_bus_read", {31'd0, bus_read}, 32'd1);
      #2; rst = 1'b1; #1;
      chk("async_rst_bus_read", {31'd0, bus_read}, 32'd0);
      chk("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("async_rst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk); rst = 1'b0;
      access(1'b1, 3'b010, 32'h0000_0300, 32'd0, 32'hDEAD_BEEF, 2, 32'h300, 4'b1111, 32'd0, 32'hDEAD_BEEF, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
